reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = requester A always wins ties.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  requester A operation request, level.
REQ-005 a_op  input  2  A operation: 00 clear, 01 load word, 10 decrement, 11 increment.
REQ-006 a_data  input  16  A load value, used only when a_op=01.
REQ-007 a_gnt  output  1  one-cycle pulse: A's request accepted.
REQ-008 a_done  output  1  one-cycle pulse: final register command of A's operation is driven this cycle.
REQ-009 b_req, b_op, b_data, b_gnt, b_done  same widths/meanings for requester B.
REQ-010 I  output  8  byte to the 16-bit register.
REQ-011 FunSel  output  2  register function select, same encoding as op.
REQ-012 LH  output  1  byte-half select for load: 0 = [7:0], 1 = [15:8].
REQ-013 enable  output  1  register write enable.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, LOAD_LO, LOAD_HI; state, winner, op and data are registered.
REQ-016 IDLE: enable=0, FunSel=00, LH=0, I=00h, gnt/done both 0.
REQ-017 In IDLE at a posedge with any req high, the winner is chosen, its op and data are captured, and next state = LOAD_LO if op=01, else EXEC.
REQ-018 Arbitration, FIXED_PRIO=0: only one req high -> that requester wins; both high -> the requester not granted last wins; last-grant register resets to B, so A wins the first tie.
REQ-019 Arbitration, FIXED_PRIO=1: A wins whenever a_req=1.
REQ-020 The winner's gnt is high for exactly the first cycle after acceptance (first EXEC or LOAD_LO cycle); the loser receives no gnt.
REQ-021 EXEC (1 cycle): enable=1, FunSel=captured op, LH=0, I=00h, winner's done=1; next state IDLE.
REQ-022 LOAD_LO (1 cycle): enable=1, FunSel=01, LH=0, I=data[7:0]; next state LOAD_HI.
REQ-023 LOAD_HI (1 cycle): enable=1, FunSel=01, LH=1, I=data[15:8], winner's done=1; next state IDLE.
REQ-024 Latency from req sampled to done: clear/inc/dec done 1 cycle after the sampling edge; load done 2 cycles after it.
REQ-025 Requests are never accepted outside IDLE; the minimum gap between consecutive operations is one IDLE cycle.
REQ-026 Requesters hold req/op/data stable until gnt; data/op changes after gnt have no effect on the operation in flight.
REQ-027 A req that deasserts before gnt is dropped with no gnt, no done and no register command.
REQ-028 A req still high in the IDLE cycle after done is a new request and goes through arbitration again.
REQ-029 Increment/decrement wrap-around is the register's concern; the controller issues FunSel only, with no range checks.
REQ-030 gnt and done for A and B are mutually exclusive; at most one requester's outputs are active per cycle.

Reset
REQ-031 rst=1 at a posedge forces state=IDLE and last-grant=B, and outputs take IDLE values in the following cycle; rst has priority over all requests.
REQ-032 Reset during LOAD_LO or LOAD_HI aborts the load with no done pulse; a low byte already written is not rolled back.
REQ-033 Requests present while rst=1 are ignored; arbitration resumes at the first posedge with rst=0.

Verification
REQ-034 Reset, then a_req=1, a_op=01, a_data=ABCDh -> cycle+1: a_gnt=1, enable=1, FunSel=01, LH=0, I=CDh; cycle+2: LH=1, I=ABh, a_done=1; cycle+3: busy=0.
REQ-035 a_req and b_req high together with op=11 after reset (FIXED_PRIO=0) -> A granted first, B granted after A's done plus one IDLE cycle; with both held high, grants alternate A,B,A.
REQ-036 FIXED_PRIO=1, both requesting continuously -> only A granted; b_gnt stays 0.
REQ-037 b_op=10 single request -> one cycle with enable=1, FunSel=10, b_gnt=1, b_done=1, then IDLE.
REQ-038 rst=1 during LOAD_HI -> no a_done, enable=0 the next cycle, busy=0; a fresh request after rst deasserts completes normally.
REQ-039 a_req pulsed for one cycle while busy on B's operation -> A request dropped, no a_gnt.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: arbitrates two requesters and sequences byte-wide commands to a 16-bit register.
// A load is issued as two byte writes; every other operation takes one command cycle.
module reg_access_ctrl #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [1:0]  a_op,
   input  logic [15:0] a_data,
   output logic        a_gnt,
   output logic        a_done,
   input  logic        b_req,
   input  logic [1:0]  b_op,
   input  logic [15:0] b_data,
   output logic        b_gnt,
   output logic        b_done,
   output logic [7:0]  I,
   output logic [1:0]  FunSel,
   output logic        LH,
   output logic        enable,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, LOAD_LO, LOAD_HI} state_t;
   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        last_q, last_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic        pick_b, gnt, done;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         op_q    <= 2'b00;
         data_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         op_q    <= op_d;
         data_q  <= data_d;
      end
   end
   // win/last encode the requester: 0 = A, 1 = B
   always_comb begin
      pick_b  = (FIXED_PRIO != 0) ? !a_req : ((a_req && b_req) ? !last_q : !a_req);
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      op_d    = op_q;
      data_d  = data_q;
      enable  = 1'b0;
      FunSel  = 2'b00;
      LH      = 1'b0;
      I       = 8'h00;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               win_d   = pick_b;
               last_d  = pick_b;
               op_d    = pick_b ? b_op : a_op;
               data_d  = pick_b ? b_data : a_data;
               state_d = (op_d == 2'b01) ? LOAD_LO : EXEC;
            end
         end
         EXEC: begin
            enable  = 1'b1;
            FunSel  = op_q;
            done    = 1'b1;
            state_d = IDLE;
         end
         LOAD_LO: begin
            enable  = 1'b1;
            FunSel  = 2'b01;
            I       = data_q[7:0];
            state_d = LOAD_HI;
         end
         LOAD_HI: begin
            enable  = 1'b1;
            FunSel  = 2'b01;
            LH      = 1'b1;
            I       = data_q[15:8];
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign gnt    = (state_q == EXEC) || (state_q == LOAD_LO);
   assign a_gnt  = gnt && !win_q;
   assign b_gnt  = gnt && win_q;
   assign a_done = done && !win_q;
   assign b_done = done && win_q;
   assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: directed and randomized checks of round-robin and fixed-priority instances
// against a transaction-level model (command list per accepted operation).
module tb_reg_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_req = 1'b0, b_req = 1'b0;
   logic [1:0] a_op = 2'b00, b_op = 2'b00;
   logic [15:0] a_data = 16'h0, b_data = 16'h0;
   logic r_agnt, r_adone, r_bgnt, r_bdone, r_lh, r_en, r_busy;
   logic f_agnt, f_adone, f_bgnt, f_bdone, f_lh, f_en, f_busy;
   logic [7:0] r_i, f_i;
   logic [1:0] r_fs, f_fs;
   logic [16:0] dv [2];
   int n_cmp = 0, n_bad = 0;
   int m_len [2], m_k [2], m_win [2], m_last [2];
   logic [1:0] m_op [2];
   logic [15:0] m_data [2];

   always #5 clk = ~clk;

   reg_access_ctrl #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_data(a_data), .a_gnt(r_agnt), .a_done(r_adone),
      .b_req(b_req), .b_op(b_op), .b_data(b_data), .b_gnt(r_bgnt), .b_done(r_bdone),
      .I(r_i), .FunSel(r_fs), .LH(r_lh), .enable(r_en), .busy(r_busy));

   reg_access_ctrl #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_data(a_data), .a_gnt(f_agnt), .a_done(f_adone),
      .b_req(b_req), .b_op(b_op), .b_data(b_data), .b_gnt(f_bgnt), .b_done(f_bdone),
      .I(f_i), .FunSel(f_fs), .LH(f_lh), .enable(f_en), .busy(f_busy));

   assign dv[0] = {r_en, r_fs, r_lh, r_i, r_agnt, r_bgnt, r_adone, r_bdone, r_busy};
   assign dv[1] = {f_en, f_fs, f_lh, f_i, f_agnt, f_bgnt, f_adone, f_bdone, f_busy};

   // Model: an accepted operation becomes a list of 1 or 2 commands, walked one per cycle.
   always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (rst) begin
            m_len[p] = 0;
            m_last[p] = 1;
         end else if (m_len[p] != 0) begin
            m_k[p]++;
            if (m_k[p] == m_len[p]) m_len[p] = 0;
         end else if (a_req || b_req) begin
            if (a_req && !b_req) m_win[p] = 0;
            else if (b_req && !a_req) m_win[p] = 1;
            else if (p == 1) m_win[p] = 0;
            else m_win[p] = (m_last[p] == 0) ? 1 : 0;
            m_last[p] = m_win[p];
            m_op[p] = (m_win[p] == 0) ? a_op : b_op;
            m_data[p] = (m_win[p] == 0) ? a_data : b_data;
            m_len[p] = (m_op[p] == 2'b01) ? 2 : 1;
            m_k[p] = 0;
         end
      end
   end

   function automatic logic [16:0] exp_vec(int p);
      logic ld, g, d;
      logic [7:0] byt;
      if (m_len[p] == 0) return 17'h0;
      ld = m_op[p] == 2'b01;
      g = m_k[p] == 0;
      d = m_k[p] == m_len[p] - 1;
      byt = !ld ? 8'h00 : (m_k[p] == 0 ? m_data[p][7:0] : m_data[p][15:8]);
      return {1'b1, m_op[p], ld && m_k[p] == 1, byt, g && m_win[p] == 0, g && m_win[p] == 1,
              d && m_win[p] == 0, d && m_win[p] == 1, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_req = 1'b1; a_op = 2'b11;
      b_req = 1'b1; b_op = 2'b01; b_data = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (dv[0] !== 17'h0 || dv[1] !== 17'h0) begin
            n_bad++;
            $display("FAIL reset cyc%0d got rr=%h fp=%h want 0", c, dv[0], dv[1]);
         end
      end
      rst = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic test_load();
      do_reset();
      a_req = 1'b1; a_op = 2'b01; a_data = 16'hABCD;
      tick();
      n_cmp++;
      if ({r_agnt, r_bgnt, r_en, r_fs, r_lh, r_i, r_adone, r_busy} !== {1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 8'hCD, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL load_lo got gnt=%b en=%b fs=%b lh=%b i=%h done=%b want gnt=1 en=1 fs=01 lh=0 i=cd done=0",
                  r_agnt, r_en, r_fs, r_lh, r_i, r_adone);
      end
      a_req = 1'b0; a_data = 16'h0000; a_op = 2'b00;
      tick();
      n_cmp++;
      if ({r_agnt, r_en, r_fs, r_lh, r_i, r_adone, r_bdone} !== {1'b0, 1'b1, 2'b01, 1'b1, 8'hAB, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL load_hi got gnt=%b en=%b fs=%b lh=%b i=%h done=%b want gnt=0 en=1 fs=01 lh=1 i=ab done=1",
                  r_agnt, r_en, r_fs, r_lh, r_i, r_adone);
      end
      n_cmp++;
      if (dv[1] !== dv[0]) begin
         n_bad++;
         $display("FAIL load_fp got %h want %h", dv[1], {1'b1, 2'b01, 1'b1, 8'hAB, 4'b0010, 1'b1});
      end
      tick();
      n_cmp++;
      if (r_busy !== 1'b0 || r_en !== 1'b0) begin
         n_bad++;
         $display("FAIL load_end got busy=%b en=%b want 0 0", r_busy, r_en);
      end
   endtask

   task automatic test_tie();
      logic [1:0] want_rr [5];
      logic [1:0] want_fp [5];
      want_rr = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      want_fp = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
      do_reset();
      a_req = 1'b1; a_op = 2'b11;
      b_req = 1'b1; b_op = 2'b11;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if ({r_agnt, r_bgnt} !== want_rr[c] || {f_agnt, f_bgnt} !== want_fp[c]) begin
            n_bad++;
            $display("FAIL tie cyc%0d got rr=%b fp=%b want rr=%b fp=%b",
                     c, {r_agnt, r_bgnt}, {f_agnt, f_bgnt}, want_rr[c], want_fp[c]);
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
   endtask

   task automatic test_dec_b();
      do_reset();
      b_req = 1'b1; b_op = 2'b10;
      tick();
      n_cmp++;
      if ({r_en, r_fs, r_lh, r_i, r_agnt, r_bgnt, r_adone, r_bdone} !== {1'b1, 2'b10, 1'b0, 8'h00, 4'b0101}) begin
         n_bad++;
         $display("FAIL dec_b got en=%b fs=%b gnt_ab=%b%b done_ab=%b%b want en=1 fs=10 gnt_ab=01 done_ab=01",
                  r_en, r_fs, r_agnt, r_bgnt, r_adone, r_bdone);
      end
      b_req = 1'b0;
      tick();
      n_cmp++;
      if (r_busy !== 1'b0 || r_en !== 1'b0 || f_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL dec_b_idle got busy=%b en=%b fp_busy=%b want 0 0 0", r_busy, r_en, f_busy);
      end
   endtask

   task automatic test_rst_abort();
      do_reset();
      a_req = 1'b1; a_op = 2'b01; a_data = 16'h1234;
      tick();
      a_req = 1'b0;
      rst = 1'b1;
      tick();
      n_cmp++;
      if (r_busy !== 1'b0 || r_en !== 1'b0 || r_adone !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_lo got busy=%b en=%b done=%b want 0 0 0", r_busy, r_en, r_adone);
      end
      rst = 1'b0;
      a_req = 1'b1; a_data = 16'h5678;
      tick();
      a_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (r_busy !== 1'b0 || r_en !== 1'b0 || r_adone !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_hi got busy=%b en=%b done=%b want 0 0 0", r_busy, r_en, r_adone);
      end
      rst = 1'b0;
      a_req = 1'b1; a_op = 2'b00;
      tick();
      n_cmp++;
      if ({r_en, r_fs, r_agnt, r_adone} !== {1'b1, 2'b00, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL after_rst got en=%b fs=%b gnt=%b done=%b want 1 00 1 1", r_en, r_fs, r_agnt, r_adone);
      end
      a_req = 1'b0;
      tick();
   endtask

   task automatic test_drop();
      do_reset();
      b_req = 1'b1; b_op = 2'b11;
      tick();
      n_cmp++;
      if (r_bgnt !== 1'b1 || r_fs !== 2'b11) begin
         n_bad++;
         $display("FAIL drop_b got gnt=%b fs=%b want 1 11", r_bgnt, r_fs);
      end
      b_req = 1'b0;
      a_req = 1'b1; a_op = 2'b11;
      tick();
      a_req = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (r_agnt !== 1'b0 || r_busy !== 1'b0 || r_en !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_a cyc%0d got gnt=%b busy=%b en=%b want 0 0 0", c, r_agnt, r_busy, r_en);
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst = $urandom_range(0, 79) == 0;
         a_req = $urandom_range(0, 2) != 0;
         b_req = $urandom_range(0, 2) != 0;
         a_op = 2'($urandom);
         b_op = 2'($urandom);
         a_data = 16'($urandom);
         b_data = 16'($urandom);
         tick();
         for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (dv[p] !== exp_vec(p)) begin
               n_bad++;
               $display("FAIL random cyc%0d inst%0d got %h want %h", c, p, dv[p], exp_vec(p));
            end
         end
      end
      rst = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_tie();
      test_dec_b();
      test_rst_abort();
      test_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
